// File: rtl/frac_cen_gen_pkg.sv
// Shared defaults, rate constants and the per-channel update request type
// for the fractional clock-enable generator.
package frac_cen_gen_pkg;

  localparam int CHANNELS_DEF = 4;
  localparam int ACC_W_DEF    = 22;
  localparam int POST_W_DEF   = 3;

  localparam int OPL2_NUM = 358;
  localparam int OPL2_DEN = 5000;
  localparam int UART_NUM = 14815;
  localparam int UART_DEN = 50000;

  typedef enum logic [1:0] {
    UPD_NONE  = 2'd0,
    UPD_NOW   = 2'd1,
    UPD_DEFER = 2'd2
  } upd_e;

  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/frac_cen_gen_if.sv
// Rate configuration port: valid/ready request with a one-cycle reject pulse.
interface frac_cen_gen_if #(
  parameter int CHANNELS = frac_cen_gen_pkg::CHANNELS_DEF,
  parameter int ACC_W    = frac_cen_gen_pkg::ACC_W_DEF,
  parameter int POST_W   = frac_cen_gen_pkg::POST_W_DEF
);
  import frac_cen_gen_pkg::*;

  localparam int CH_W = ch_idx_w(CHANNELS);

  logic              cfg_valid;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch;
  logic [ACC_W-1:0]  cfg_num;
  logic [ACC_W-1:0]  cfg_den;
  logic [POST_W-1:0] cfg_post;
  logic              cfg_sync;
  logic              cfg_err;

  modport master (
    output cfg_valid, cfg_ch, cfg_num, cfg_den, cfg_post, cfg_sync,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_num, cfg_den, cfg_post, cfg_sync,
    output cfg_ready, cfg_err
  );

endinterface

// File: rtl/frac_cen_channel.sv
// One fractional enable channel: phase accumulator, post divider and a
// shadow config that is swapped in on the channel's own enable pulse.
module frac_cen_channel
  import frac_cen_gen_pkg::*;
#(
  parameter int ACC_W  = ACC_W_DEF,
  parameter int POST_W = POST_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_restart,
  input  upd_e              i_upd,
  input  logic [ACC_W-1:0]  i_num,
  input  logic [ACC_W-1:0]  i_den,
  input  logic [POST_W-1:0] i_post,
  output logic              o_pend,
  output logic              o_cen,
  output logic              o_cen_post
);

  logic [ACC_W-1:0]  r_acc;
  logic [ACC_W-1:0]  r_num;
  logic [ACC_W-1:0]  r_den;
  logic [POST_W-1:0] r_post;
  logic [POST_W-1:0] r_pc;
  logic              r_pend;
  logic [ACC_W-1:0]  r_sh_num;
  logic [ACC_W-1:0]  r_sh_den;
  logic [POST_W-1:0] r_sh_post;
  logic              r_cen_p1;
  logic              r_cen_post_p1;

  logic [ACC_W:0]    w_nxt_p0;
  logic              w_hit_p0;
  logic              w_wrap_p0;

  // Stage p0: accumulate and compare against the modulus
  assign w_nxt_p0  = {1'b0, r_acc} + {1'b0, r_num};
  assign w_hit_p0  = (w_nxt_p0 >= {1'b0, r_den});
  assign w_wrap_p0 = w_hit_p0 && (r_pc == r_post);

  // Stage p1: registered enables, new phase and config
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc         <= '0;
      r_num         <= '0;
      r_den         <= ACC_W'(1);
      r_post        <= '0;
      r_pc          <= '0;
      r_pend        <= 1'b0;
      r_cen_p1      <= 1'b0;
      r_cen_post_p1 <= 1'b0;
    end else if (i_restart) begin
      r_acc         <= '0;
      r_pc          <= '0;
      r_pend        <= 1'b0;
      r_cen_p1      <= 1'b0;
      r_cen_post_p1 <= 1'b0;
      if (i_upd == UPD_NOW) begin
        r_num  <= i_num;
        r_den  <= i_den;
        r_post <= i_post;
      end else if (r_pend) begin
        r_num  <= r_sh_num;
        r_den  <= r_sh_den;
        r_post <= r_sh_post;
      end
    end else begin
      r_cen_p1      <= w_hit_p0;
      r_cen_post_p1 <= w_wrap_p0;
      if (i_upd == UPD_NOW) begin
        r_num  <= i_num;
        r_den  <= i_den;
        r_post <= i_post;
        r_acc  <= '0;
        r_pc   <= '0;
      end else if (r_pend && w_hit_p0) begin
        r_num  <= r_sh_num;
        r_den  <= r_sh_den;
        r_post <= r_sh_post;
        r_acc  <= '0;
        r_pc   <= '0;
        r_pend <= 1'b0;
      end else begin
        if (i_upd == UPD_DEFER) begin
          r_pend <= 1'b1;
        end
        r_acc <= w_hit_p0 ? ACC_W'(w_nxt_p0 - {1'b0, r_den}) : w_nxt_p0[ACC_W-1:0];
        if (w_hit_p0) begin
          r_pc <= w_wrap_p0 ? '0 : r_pc + POST_W'(1);
        end
      end
    end
  end

  // Shadow values are only consumed while pend is set, so they carry no reset
  always_ff @(posedge i_clk) begin
    if (i_upd == UPD_DEFER) begin
      r_sh_num  <= i_num;
      r_sh_den  <= i_den;
      r_sh_post <= i_post;
    end
  end

  assign o_pend     = r_pend;
  assign o_cen      = r_cen_p1;
  assign o_cen_post = r_cen_post_p1;

endmodule

// File: rtl/frac_cen_gen.sv
// Multi-channel fractional clock-enable generator: config validation,
// reset release synchroniser and CHANNELS accumulator channels.
module frac_cen_gen
  import frac_cen_gen_pkg::*;
#(
  parameter int CHANNELS = CHANNELS_DEF,
  parameter int ACC_W    = ACC_W_DEF,
  parameter int POST_W   = POST_W_DEF
) (
  input  logic                i_clk_chipset,
  input  logic                i_reset_n,
  input  logic                i_restart,
  frac_cen_gen_if.slave       cfg,
  output logic [CHANNELS-1:0] o_cen,
  output logic [CHANNELS-1:0] o_cen_post
);

  logic [1:0]          r_rst_sync;
  logic                w_rst_n;
  logic                w_xfer;
  logic                w_bad;
  logic                r_cfg_err;
  logic [CHANNELS-1:0] w_pend;
  upd_e                w_upd [CHANNELS];

  // Assert asynchronously, release two clocks later
  always_ff @(posedge i_clk_chipset or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_n = r_rst_sync[1];

  assign w_xfer = cfg.cfg_valid & cfg.cfg_ready;
  assign w_bad  = (cfg.cfg_den == '0) || (cfg.cfg_num > cfg.cfg_den) ||
                  (int'(cfg.cfg_ch) >= CHANNELS);

  // A deferred request arriving with restart is applied immediately
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      w_upd[i] = UPD_NONE;
      if (w_xfer && !w_bad && (int'(cfg.cfg_ch) == i)) begin
        w_upd[i] = (cfg.cfg_sync && !i_restart) ? UPD_DEFER : UPD_NOW;
      end
    end
  end

  always_ff @(posedge i_clk_chipset or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= w_xfer & w_bad;
    end
  end

  assign cfg.cfg_ready = ~|w_pend;
  assign cfg.cfg_err   = r_cfg_err;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    frac_cen_channel #(
      .ACC_W  (ACC_W),
      .POST_W (POST_W)
    ) u_ch (
      .i_clk      (i_clk_chipset),
      .i_rst_n    (w_rst_n),
      .i_restart  (i_restart),
      .i_upd      (w_upd[g]),
      .i_num      (cfg.cfg_num),
      .i_den      (cfg.cfg_den),
      .i_post     (cfg.cfg_post),
      .o_pend     (w_pend[g]),
      .o_cen      (o_cen[g]),
      .o_cen_post (o_cen_post[g])
    );
  end

endmodule

// File: tb/tb_frac_cen_gen.sv
// Directed bench for frac_cen_gen: rates, post divide, rejects, deferred
// update, restart and mid-run reset, with hand-computed expectations.
module tb_frac_cen_gen;
  import frac_cen_gen_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       restart = 1'b0;
  logic [3:0] cen;
  logic [3:0] cen_post;

  frac_cen_gen_if #(.CHANNELS(4), .ACC_W(22), .POST_W(3)) cfg_if ();

  frac_cen_gen #(.CHANNELS(4), .ACC_W(22), .POST_W(3)) dut (
    .i_clk_chipset (clk),
    .i_reset_n     (rst_n),
    .i_restart     (restart),
    .cfg           (cfg_if),
    .o_cen         (cen),
    .o_cen_post    (cen_post)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int cnt_cen [4];
  int cnt_post [4];
  int adj [4];
  int bad_post [4];
  int last [4];
  int gap [4];
  logic [3:0] prev_cen = 4'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 4; i++) begin
      if (cen[i] === 1'b1) begin
        cnt_cen[i]++;
        gap[i]  = cyc - last[i];
        last[i] = cyc;
        if (prev_cen[i] === 1'b1) adj[i]++;
      end
      if (cen_post[i] === 1'b1) begin
        cnt_post[i]++;
        if (cen[i] !== 1'b1) bad_post[i]++;
      end
    end
    prev_cen = cen;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic clr();
    for (int i = 0; i < 4; i++) begin
      cnt_cen[i]  = 0;
      cnt_post[i] = 0;
      adj[i]      = 0;
      bad_post[i] = 0;
    end
  endtask

  task automatic set_cfg(input int ch, input int num, input int den, input int post, input bit sync);
    cfg_if.cfg_ch   = 2'(ch);
    cfg_if.cfg_num  = 22'(num);
    cfg_if.cfg_den  = 22'(den);
    cfg_if.cfg_post = 3'(post);
    cfg_if.cfg_sync = sync;
  endtask

  task automatic cfg_write(input int ch, input int num, input int den, input int post, input bit sync);
    set_cfg(ch, num, den, post, sync);
    cfg_if.cfg_valid = 1'b1;
    step();
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic wait_cen(input int ch, input int max, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < max; k++) begin
      step();
      if (cen[ch] === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    bit ok;
    clr();
    for (int i = 0; i < 4; i++) begin
      last[i] = 0;
      gap[i]  = 0;
    end
    cfg_if.cfg_valid = 1'b0;
    set_cfg(0, 0, 1, 0, 1'b0);

    // reset state
    #1 rst_n = 1'b0;
    run(3);
    chk("rst_cen", cen, 0);
    chk("rst_cen_post", cen_post, 0);
    chk("rst_ready", cfg_if.cfg_ready, 1);
    chk("rst_err", cfg_if.cfg_err, 0);
    rst_n = 1'b1;
    run(2);

    // OPL2 rate on ch0, no post divide
    cfg_write(0, OPL2_NUM, OPL2_DEN, 0, 1'b0);
    chk("opl2_err", cfg_if.cfg_err, 0);
    clr();
    run(5000);
    chk("opl2_count", cnt_cen[0], 358);
    chk("opl2_adjacent", adj[0], 0);
    chk("opl2_post_count", cnt_post[0], 358);
    chk("opl2_post_align", bad_post[0], 0);

    // UART rate on ch1 with /8 post divide
    cfg_write(1, UART_NUM, UART_DEN, 7, 1'b0);
    clr();
    run(50000);
    chk("uart_count", cnt_cen[1], 14815);
    chk("uart_post_count", cnt_post[1], 1851);
    chk("uart_post_align", bad_post[1], 0);
    chk("opl2_during_uart", cnt_cen[0], 3580);

    // rejected configs leave ch0 untouched
    cfg_write(0, 6, 5, 0, 1'b0);
    chk("rej_num_gt_den_err", cfg_if.cfg_err, 1);
    step();
    chk("rej_err_one_cycle", cfg_if.cfg_err, 0);
    cfg_write(0, 1, 0, 0, 1'b0);
    chk("rej_den_zero_err", cfg_if.cfg_err, 1);
    chk("rej_ready", cfg_if.cfg_ready, 1);
    clr();
    run(5000);
    chk("rej_rate_kept", cnt_cen[0], 358);

    // deferred update on ch2: 1/4 then 1/2 from its next pulse
    cfg_write(2, 1, 4, 0, 1'b0);
    wait_cen(2, 8, ok);
    chk("defer_first_pulse", ok, 1);
    cfg_write(2, 1, 2, 0, 1'b1);
    chk("defer_ready_low_a", cfg_if.cfg_ready, 0);
    step();
    chk("defer_no_pulse", cen[2], 0);
    step();
    chk("defer_ready_low_b", cfg_if.cfg_ready, 0);
    step();
    chk("defer_pulse_old", cen[2], 1);
    chk("defer_gap_old", gap[2], 4);
    chk("defer_ready_back", cfg_if.cfg_ready, 1);
    run(2);
    chk("defer_pulse_new", cen[2], 1);
    chk("defer_gap_new", gap[2], 2);
    clr();
    run(5000);
    chk("defer_ch0_undisturbed", cnt_cen[0], 358);
    chk("defer_ch2_rate", cnt_cen[2], 2500);

    // deferred update on silent ch3 waits until restart
    clr();
    cfg_write(3, 1, 3, 0, 1'b1);
    run(5);
    chk("silent_pend_ready", cfg_if.cfg_ready, 0);
    chk("silent_no_pulse", cnt_cen[3], 0);
    restart = 1'b1;
    step();
    restart = 1'b0;
    chk("restart_cen", cen, 0);
    chk("restart_cen_post", cen_post, 0);
    chk("restart_ready", cfg_if.cfg_ready, 1);
    step();
    chk("restart_phase_1", cen, 4'b0000);
    step();
    chk("restart_phase_2", cen, 4'b0100);
    step();
    chk("restart_phase_3", cen, 4'b1000);
    step();
    chk("restart_phase_4", cen, 4'b0110);
    chk("restart_post_4", cen_post, 4'b0100);

    // deferred request together with restart is applied at once
    set_cfg(3, 1, 1, 0, 1'b1);
    cfg_if.cfg_valid = 1'b1;
    restart = 1'b1;
    step();
    restart = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    chk("restart_cfg_ready", cfg_if.cfg_ready, 1);
    step();
    chk("restart_cfg_applied", cen[3], 1);

    // asynchronous reset mid-run
    step();
    chk("pre_reset_pulse", cen[3], 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_cen", cen, 0);
    chk("async_rst_cen_post", cen_post, 0);
    chk("async_rst_ready", cfg_if.cfg_ready, 1);
    run(3);
    rst_n = 1'b1;
    clr();
    run(30);
    chk("post_reset_silent", cnt_cen[0] + cnt_cen[1] + cnt_cen[2] + cnt_cen[3], 0);
    cfg_write(3, 1, 1, 0, 1'b0);
    step();
    chk("post_reset_reconfig", cen[3], 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
